// File: rtl/sram_bus_arbiter_if.sv
// Requester-side bus of sram_bus_arbiter.
// Carries the fetch (A) and data (B) req/ack handshakes plus the
// pipeline stall. The arbiter connects through the slave modport, the
// CPU side through the master modport.
//   a_req/a_addr            fetch read request and address
//   a_rdata/a_ack           fetch read data and one-cycle completion pulse
//   b_req/b_we/b_addr/b_wdata data request, direction, address, write data
//   b_rdata/b_ack           data read result and one-cycle completion pulse
//   stall                   combinational: a request is outstanding
interface sram_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_rdata;
  logic              a_ack;
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic [DATA_W-1:0] b_rdata;
  logic              b_ack;
  logic              stall;

  modport master (
    output a_req, a_addr,
    input  a_rdata, a_ack,
    output b_req, b_we, b_addr, b_wdata,
    input  b_rdata, b_ack, stall
  );

  modport slave (
    input  a_req, a_addr,
    output a_rdata, a_ack,
    input  b_req, b_we, b_addr, b_wdata,
    output b_rdata, b_ack, stall
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares one asynchronous SRAM between the instruction-fetch requester (A)
// and the data-memory requester (B). Sequences multi-cycle read and write
// cycles, drives the SRAM strobes and the tri-state data bus, and returns
// one-cycle acks. B wins a simultaneous request unless ARB_ROUND_ROBIN_EN
// is defined, in which case a tie goes to the side not granted last.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   bus           requester handshakes (sram_bus_arbiter_if.slave)
//   sram_addr     SRAM address
//   sram_data     SRAM data bus, driven only during write cycles
//   sram_en_n     chip enable, active-low
//   sram_oe_n     output enable, active-low
//   sram_we_n     write enable, active-low
module sram_bus_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned RD_WAIT  = 1,
  parameter int unsigned WR_PULSE = 1
) (
  input  logic              clk,
  input  logic              rst,
  sram_bus_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_en_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               owner_b_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               drive_q;
  logic               a_ack_q, b_ack_q;
  logic [DATA_W-1:0]  a_rdata_q, b_rdata_q;
  logic               grant_a, grant_b;
  logic               tie_to_b;

  // Tie-break between simultaneous requests
`ifdef ARB_ROUND_ROBIN_EN
  logic last_b_q;
  assign tie_to_b = ~last_b_q;

  // Last-owner flag; resets to "A last" so the first contended grant is B
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_b_q <= 1'b0;
    end else if (grant_a || grant_b) begin
      last_b_q <= grant_b;
    end
  end
`else
  assign tie_to_b = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, grant and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.b_req && (!bus.a_req || tie_to_b)) begin
          grant_b = 1'b1;
        end else if (bus.a_req) begin
          grant_a = 1'b1;
        end
        if (grant_b && bus.b_we) begin
          state_d = ST_WR_SETUP;
        end else if (grant_a || grant_b) begin
          state_d = ST_RD;
          cnt_d   = CNT_W'(RD_WAIT);
        end
      end
      ST_RD: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
        cnt_d   = CNT_W'(WR_PULSE - 1);
      end
      ST_WR_PULSE: begin
        if (cnt_q == '0) state_d = ST_WR_HOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_WR_HOLD: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Registered strobes, acks, latched request and read data.
  // Strobes are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_en_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      drive_q   <= 1'b0;
      sram_addr <= '0;
      wdata_q   <= '0;
      owner_b_q <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      sram_en_n <= (state_d == ST_IDLE);
      sram_oe_n <= (state_d != ST_RD);
      sram_we_n <= (state_d != ST_WR_PULSE);
      drive_q   <= (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) ||
                   (state_d == ST_WR_HOLD);
      // DONE is only reached from RD or WR_HOLD, so owner is already latched
      a_ack_q   <= (state_d == ST_DONE) && !owner_b_q;
      b_ack_q   <= (state_d == ST_DONE) &&  owner_b_q;

      if (grant_a || grant_b) begin
        owner_b_q <= grant_b;
        sram_addr <= grant_b ? bus.b_addr : bus.a_addr;
        wdata_q   <= bus.b_wdata;
      end

      // Sample the bus at the edge that ends the last RD cycle
      if (state_q == ST_RD && cnt_q == '0) begin
        if (owner_b_q) b_rdata_q <= sram_data;
        else           a_rdata_q <= sram_data;
      end
    end
  end

  assign sram_data   = drive_q ? wdata_q : {DATA_W{1'bz}};

  assign bus.a_ack   = a_ack_q;
  assign bus.b_ack   = b_ack_q;
  assign bus.a_rdata = a_rdata_q;
  assign bus.b_rdata = b_rdata_q;
  assign bus.stall   = (bus.a_req & ~a_ack_q) | (bus.b_req & ~b_ack_q);

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Testbench for sram_bus_arbiter: directed latency/strobe scenarios on a
// default-timing instance and a slow-timing instance, plus randomized
// traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_sram_bus_arbiter;
  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 16;
  localparam int          RDW  = 1;
  localparam int          WRP  = 1;
  localparam int          RDW2 = 3;
  localparam int          WRP2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  // Power-up SRAM content for words never written
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5234;
  endfunction

  // ---------------- default-timing instance ----------------
  sram_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  wire  [DW-1:0] sram_data;
  logic [AW-1:0] sram_addr;
  logic          sram_en_n, sram_oe_n, sram_we_n;
  logic          probe_en;

  sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RDW), .WR_PULSE(WRP)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_en_n(sram_en_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  logic [15:0] mem     [0:65535];
  bit          written [0:65535];
  assign sram_data = (!sram_en_n && !sram_oe_n) ?
                     (written[sram_addr] ? mem[sram_addr] : init_val(sram_addr)) : {DW{1'bz}};
  // Probe: drives zero so a stray DUT driver shows up as nonzero
  assign sram_data = probe_en ? {DW{1'b0}} : {DW{1'bz}};
  always @(posedge clk) begin
    if (!sram_en_n && !sram_we_n) begin
      mem[sram_addr]     <= sram_data;
      written[sram_addr] <= 1'b1;
    end
  end

  // ---------------- slow-timing instance ----------------
  sram_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();
  wire  [DW-1:0] sram_data2;
  logic [AW-1:0] sram_addr2;
  logic          sram_en2_n, sram_oe2_n, sram_we2_n;

  sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RDW2), .WR_PULSE(WRP2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .sram_addr(sram_addr2), .sram_data(sram_data2),
    .sram_en_n(sram_en2_n), .sram_oe_n(sram_oe2_n), .sram_we_n(sram_we2_n)
  );

  logic [15:0] mem2     [0:65535];
  bit          written2 [0:65535];
  assign sram_data2 = (!sram_en2_n && !sram_oe2_n) ?
                      (written2[sram_addr2] ? mem2[sram_addr2] : init_val(sram_addr2)) : {DW{1'bz}};
  always @(posedge clk) begin
    if (!sram_en2_n && !sram_we2_n) begin
      mem2[sram_addr2]     <= sram_data2;
      written2[sram_addr2] <= 1'b1;
    end
  end

  // oe_n and we_n must never be low together on either instance
  always @(negedge clk) begin
    assert (sram_oe_n || sram_we_n) else $error("FAIL oe_we_overlap dut");
    assert (sram_oe2_n || sram_we2_n) else $error("FAIL oe_we_overlap dut2");
  end

  // Waits for the requested acks, dropping each req as its ack is seen.
  // Cycle numbers count the request-sampling cycle as 0; -1 means no ack.
  task automatic track(input bit want_a, input bit want_b, input int max_k,
                       output int a_cyc, output int b_cyc,
                       output logic [15:0] a_dat, output logic [15:0] b_dat);
    a_cyc = -1; b_cyc = -1; a_dat = '0; b_dat = '0;
    for (int k = 1; k <= max_k; k++) begin
      @(negedge clk);
      if (want_a && a_cyc < 0 && bus.a_ack) begin
        a_cyc = k; a_dat = bus.a_rdata; bus.a_req = 1'b0;
      end
      if (want_b && b_cyc < 0 && bus.b_ack) begin
        b_cyc = k; b_dat = bus.b_rdata; bus.b_req = 1'b0;
      end
      if ((!want_a || a_cyc >= 0) && (!want_b || b_cyc >= 0)) break;
    end
  endtask

  task automatic test_reset();
    int a_cyc, b_cyc;
    logic [15:0] a_dat, b_dat;
    rst = 1'b0; probe_en = 1'b1;
    bus.a_req = 1'b1; bus.a_addr = 16'h0100;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 16'h0200;
    repeat (3) @(negedge clk);
    checks++;
    if ({sram_en_n, sram_oe_n, sram_we_n} !== 3'b111) begin
      errors++; $display("FAIL reset_strobes got %b want 111", {sram_en_n, sram_oe_n, sram_we_n});
    end
    checks++;
    if (sram_data !== 16'h0000) begin
      errors++; $display("FAIL reset_bus_released got %h want 0000", sram_data);
    end
    checks++;
    if ({bus.a_ack, bus.b_ack} !== 2'b00) begin
      errors++; $display("FAIL reset_acks got %b want 00", {bus.a_ack, bus.b_ack});
    end
    checks++;
    if ({sram_addr, bus.a_rdata, bus.b_rdata} !== 48'h0) begin
      errors++; $display("FAIL reset_regs got %h want 0", {sram_addr, bus.a_rdata, bus.b_rdata});
    end
    rst = 1'b1; probe_en = 1'b0;
    track(1'b1, 1'b1, 20, a_cyc, b_cyc, a_dat, b_dat);
    checks++;
    if (b_cyc != RDW + 2) begin
      errors++; $display("FAIL reset_first_grant_b b_ack cycle %0d want %0d", b_cyc, RDW + 2);
    end
    checks++;
    if (a_cyc != 2 * (RDW + 3) - 1) begin
      errors++; $display("FAIL reset_then_a a_ack cycle %0d want %0d", a_cyc, 2 * (RDW + 3) - 1);
    end
    checks++;
    if (b_dat !== init_val(16'h0200) || a_dat !== init_val(16'h0100)) begin
      errors++; $display("FAIL reset_rdata got %h/%h want %h/%h", b_dat, a_dat,
                         init_val(16'h0200), init_val(16'h0100));
    end
  endtask

  task automatic test_contention();
    int a_cyc, b_cyc;
    logic [15:0] a_dat, b_dat;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      bus.a_req = 1'b1; bus.a_addr = 16'h0010 + 16'(r);
      bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 16'h0020 + 16'(r);
      track(1'b1, 1'b1, 20, a_cyc, b_cyc, a_dat, b_dat);
      checks++;
      if (b_cyc != RDW + 2 || a_cyc != 2 * (RDW + 3) - 1) begin
        errors++; $display("FAIL contention_order round %0d b=%0d a=%0d want b=%0d a=%0d",
                           r, b_cyc, a_cyc, RDW + 2, 2 * (RDW + 3) - 1);
      end
      checks++;
      if (b_dat !== init_val(16'h0020 + 16'(r)) || a_dat !== init_val(16'h0010 + 16'(r))) begin
        errors++; $display("FAIL contention_data round %0d got %h/%h", r, b_dat, a_dat);
      end
    end
  endtask

  task automatic test_read_a();
    int oe_cnt = 0, oe_first = -1, ack_cyc = -1;
    logic stall2 = 1'b0, stall4 = 1'b1, en1 = 1'b1;
    logic [15:0] rdat = '0, addr1 = '0;
    @(negedge clk);
    bus.a_req = 1'b1; bus.a_addr = 16'h0040;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!sram_oe_n) begin
        oe_cnt++;
        if (oe_first < 0) oe_first = k;
      end
      if (k == 1) begin en1 = sram_en_n; addr1 = sram_addr; end
      if (k == 2) stall2 = bus.stall;
      if (k == 4) stall4 = bus.stall;
      if (bus.a_ack && ack_cyc < 0) begin
        ack_cyc = k; rdat = bus.a_rdata; bus.a_req = 1'b0;
      end
    end
    checks++;
    if (ack_cyc != 3) begin errors++; $display("FAIL read_ack_cycle got %0d want 3", ack_cyc); end
    checks++;
    if (rdat !== 16'h1234) begin errors++; $display("FAIL read_data got %h want 1234", rdat); end
    checks++;
    if (oe_cnt != 2 || oe_first != 1) begin
      errors++; $display("FAIL read_oe got %0d cycles from %0d want 2 from 1", oe_cnt, oe_first);
    end
    checks++;
    if (stall2 !== 1'b1 || stall4 !== 1'b0) begin
      errors++; $display("FAIL read_stall got c2=%b c4=%b want 1/0", stall2, stall4);
    end
    checks++;
    if (en1 !== 1'b0 || addr1 !== 16'h0040) begin
      errors++; $display("FAIL read_en_addr got en=%b addr=%h want 0/0040", en1, addr1);
    end
    checks++;
    if (bus.a_rdata !== 16'h1234) begin
      errors++; $display("FAIL read_data_hold got %h want 1234", bus.a_rdata);
    end
  endtask

  task automatic test_write_b();
    int we_cnt = 0, we_first = -1, ack_cyc = -1, oe_cnt = 0;
    bit drv_ok = 1'b1;
    @(negedge clk);
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 16'h8001; bus.b_wdata = 16'hBEEF;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!sram_we_n) begin
        we_cnt++;
        if (we_first < 0) we_first = k;
      end
      if (!sram_oe_n) oe_cnt++;
      if (k >= 1 && k <= 3 && sram_data !== 16'hBEEF) drv_ok = 1'b0;
      // Inputs change after grant and must be ignored
      if (k == 1) begin bus.b_addr = 16'h1111; bus.b_wdata = 16'h2222; bus.b_we = 1'b0; end
      if (bus.b_ack && ack_cyc < 0) begin ack_cyc = k; bus.b_req = 1'b0; end
    end
    checks++;
    if (ack_cyc != 4) begin errors++; $display("FAIL write_ack_cycle got %0d want 4", ack_cyc); end
    checks++;
    if (we_cnt != 1 || we_first != 2) begin
      errors++; $display("FAIL write_we_pulse got %0d cycles from %0d want 1 from 2", we_cnt, we_first);
    end
    checks++;
    if (!drv_ok) begin errors++; $display("FAIL write_bus_drive got %b want 1", drv_ok); end
    checks++;
    if (oe_cnt != 0) begin errors++; $display("FAIL write_oe got %0d want 0", oe_cnt); end
    checks++;
    if (!written[16'h8001] || mem[16'h8001] !== 16'hBEEF) begin
      errors++; $display("FAIL write_mem got %h want beef", mem[16'h8001]);
    end
  endtask

  task automatic test_reset_mid_write();
    int ack_cnt = 0;
    @(negedge clk);
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 16'h9077; bus.b_wdata = 16'hA5A5;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sram_we_n !== 1'b0) begin errors++; $display("FAIL midrst_in_pulse we_n got %b want 0", sram_we_n); end
    #1 rst = 1'b0; probe_en = 1'b1;
    #1;
    checks++;
    if ({sram_en_n, sram_oe_n, sram_we_n} !== 3'b111) begin
      errors++; $display("FAIL midrst_strobes got %b want 111", {sram_en_n, sram_oe_n, sram_we_n});
    end
    checks++;
    if (sram_data !== 16'h0000) begin errors++; $display("FAIL midrst_bus_released got %h want 0000", sram_data); end
    bus.b_req = 1'b0; bus.b_we = 1'b0;
    @(negedge clk);
    rst = 1'b1; probe_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (bus.b_ack) ack_cnt++;
      @(negedge clk);
    end
    checks++;
    if (ack_cnt != 0) begin errors++; $display("FAIL midrst_no_ack got %0d acks want 0", ack_cnt); end
  endtask

  task automatic test_slow_timing();
    int oe_cnt = 0, we_cnt = 0, ack_cyc = -1;
    logic [15:0] rdat = '0;
    @(negedge clk);
    bus2.a_req = 1'b1; bus2.a_addr = 16'h0005;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (!sram_oe2_n) oe_cnt++;
      if (bus2.a_ack && ack_cyc < 0) begin ack_cyc = k; rdat = bus2.a_rdata; bus2.a_req = 1'b0; end
    end
    checks++;
    if (ack_cyc != RDW2 + 2 || oe_cnt != RDW2 + 1) begin
      errors++; $display("FAIL slow_read ack %0d oe %0d want %0d/%0d", ack_cyc, oe_cnt, RDW2 + 2, RDW2 + 1);
    end
    checks++;
    if (rdat !== init_val(16'h0005)) begin errors++; $display("FAIL slow_read_data got %h want %h", rdat, init_val(16'h0005)); end
    ack_cyc = -1;
    bus2.b_req = 1'b1; bus2.b_we = 1'b1; bus2.b_addr = 16'h0006; bus2.b_wdata = 16'h0F0F;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (!sram_we2_n) we_cnt++;
      if (bus2.b_ack && ack_cyc < 0) begin ack_cyc = k; bus2.b_req = 1'b0; end
    end
    checks++;
    if (ack_cyc != WRP2 + 3 || we_cnt != WRP2) begin
      errors++; $display("FAIL slow_write ack %0d we %0d want %0d/%0d", ack_cyc, we_cnt, WRP2 + 3, WRP2);
    end
    checks++;
    if (mem2[16'h0006] !== 16'h0F0F) begin errors++; $display("FAIL slow_write_mem got %h want 0f0f", mem2[16'h0006]); end
  endtask

  // Transaction-level model: one transfer at a time, grant at an idle
  // sampling edge, ack a fixed latency later, next grant the cycle after ack.
  task automatic test_random();
    logic [15:0] gold [0:255];
    int free_c = 0, a_ack_c = -1, b_ack_c = -1, bad = 0;
    bit a_busy = 0, a_gnt = 0, b_busy = 0, b_gnt = 0, b_wr = 0, last_b = 0;
    bit exp_a, exp_b, pa, pb, take_b, exp_stall;
    logic [15:0] a_exp = '0, b_exp = '0, a_last = '0, b_last = '0, got;
    for (int i = 0; i < 256; i++) gold[i] = init_val(16'(i));
    @(negedge clk);
    rst = 1'b0;
    bus.a_req = 1'b0; bus.b_req = 1'b0; bus.b_we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 600; c++) begin
      exp_a = a_gnt && (c == a_ack_c);
      exp_b = b_gnt && (c == b_ack_c);
      if (exp_a) a_last = a_exp;
      if (exp_b && !b_wr) b_last = b_exp;
      exp_stall = (bus.a_req & ~exp_a) | (bus.b_req & ~exp_b);
      checks++;
      if (bus.a_ack !== exp_a || bus.b_ack !== exp_b) begin
        errors++; $display("FAIL rand_ack cycle %0d got a=%b b=%b want a=%b b=%b", c, bus.a_ack, bus.b_ack, exp_a, exp_b);
      end
      checks++;
      if (bus.a_rdata !== a_last || bus.b_rdata !== b_last) begin
        errors++; $display("FAIL rand_rdata cycle %0d got a=%h b=%h want a=%h b=%h", c, bus.a_rdata, bus.b_rdata, a_last, b_last);
      end
      checks++;
      if (bus.stall !== exp_stall) begin
        errors++; $display("FAIL rand_stall cycle %0d got %b want %b", c, bus.stall, exp_stall);
      end
      // Requester agents
      if (exp_a) begin a_busy = 0; a_gnt = 0; bus.a_req = 1'b0; end
      else if (a_gnt) bus.a_addr = 16'($urandom);
      else if (!a_busy && $urandom_range(0, 3) == 0) begin
        a_busy = 1; bus.a_req = 1'b1; bus.a_addr = 16'($urandom_range(0, 255));
      end
      if (exp_b) begin b_busy = 0; b_gnt = 0; bus.b_req = 1'b0; end
      else if (b_gnt) begin bus.b_addr = 16'($urandom); bus.b_wdata = 16'($urandom); bus.b_we = 1'($urandom); end
      else if (!b_busy && $urandom_range(0, 3) == 0) begin
        b_busy = 1; bus.b_req = 1'b1; bus.b_we = 1'($urandom);
        bus.b_addr = 16'($urandom_range(0, 255)); bus.b_wdata = 16'($urandom);
      end
      // Arbitration at the edge ending this cycle
      if (c >= free_c) begin
        pa = a_busy && !a_gnt;
        pb = b_busy && !b_gnt;
`ifdef ARB_ROUND_ROBIN_EN
        take_b = pb && (!pa || !last_b);
`else
        take_b = pb;
`endif
        if (take_b) begin
          b_gnt = 1; b_wr = bus.b_we; last_b = 1;
          b_ack_c = c + (b_wr ? WRP + 3 : RDW + 2);
          free_c = b_ack_c + 1;
          if (b_wr) gold[bus.b_addr[7:0]] = bus.b_wdata;
          else      b_exp = gold[bus.b_addr[7:0]];
        end else if (pa) begin
          a_gnt = 1; last_b = 0;
          a_ack_c = c + RDW + 2;
          free_c = a_ack_c + 1;
          a_exp = gold[bus.a_addr[7:0]];
        end
      end
      @(negedge clk);
    end
    if (!a_gnt) bus.a_req = 1'b0;
    if (!b_gnt) bus.b_req = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.a_ack) bus.a_req = 1'b0;
      if (bus.b_ack) bus.b_req = 1'b0;
    end
    for (int i = 0; i < 256; i++) begin
      got = written[i] ? mem[i] : init_val(16'(i));
      if (got !== gold[i]) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rand_mem_contents got %0d bad words want 0", bad); end
  endtask

  initial begin
    rst = 1'b0; probe_en = 1'b0;
    bus.a_req = 1'b0; bus.a_addr = '0; bus.b_req = 1'b0; bus.b_we = 1'b0;
    bus.b_addr = '0; bus.b_wdata = '0;
    bus2.a_req = 1'b0; bus2.a_addr = '0; bus2.b_req = 1'b0; bus2.b_we = 1'b0;
    bus2.b_addr = '0; bus2.b_wdata = '0;
    @(negedge clk);
    test_reset();
    test_contention();
    test_read_a();
    test_write_b();
    test_reset_mid_write();
    test_slow_timing();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one asynchronous 16-bit SRAM between the instruction-fetch requester (A side) and the data-memory requester (B side) of the pipelined CPU.
- Sequences multi-cycle SRAM read and write cycles, drives the SRAM control strobes and the tri-state data bus, and returns req/ack handshakes.
- Raises a pipeline stall while any request is outstanding.
- Sits between the address-decode logic and the board SRAM pins.

Parameters:
- ADDR_W, 16, address width on both requesters and the SRAM.
- DATA_W, 16, data width.
- RD_WAIT, 1, extra read cycles with OE asserted before data is sampled (range 0-7).
- WR_PULSE, 1, number of cycles WE is held low (range 1-7).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: asynchronous, active-low.
- a_req  in  1  fetch read request; held high until a_ack.
- a_addr  in  ADDR_W  fetch address.
- a_rdata  out  DATA_W  fetch read data; valid while a_ack=1.
- a_ack  out  1  one-cycle completion pulse for the fetch side.
- b_req  in  1  data request; held high until b_ack.
- b_we  in  1  1 = write, 0 = read; sampled at grant.
- b_addr  in  ADDR_W  data address.
- b_wdata  in  DATA_W  write data.
- b_rdata  out  DATA_W  data read result; valid while b_ack=1.
- b_ack  out  1  one-cycle completion pulse for the data side.
- stall  out  1  combinational: (a_req & ~a_ack) | (b_req & ~b_ack).
- sram_addr  out  ADDR_W  SRAM address.
- sram_data  inout  DATA_W  SRAM data bus.
- sram_en_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.

Behaviour:
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- Reset (async, rst=0):
  - state goes to IDLE.
  - sram_en_n, sram_oe_n and sram_we_n go to 1; sram_data is high-Z; sram_addr goes to 0.
  - a_ack, b_ack go to 0; a_rdata, b_rdata go to 0; the wait counter and grant-owner register clear.
  - Reset asserted mid-cycle aborts the cycle immediately; no ack is issued.
- IDLE: if any request is pending, grant it at the clock edge.
  - Priority is B over A (default).
  - Latch the owner, address, b_we and b_wdata. Later input changes are ignored until DONE.
  - sram_en_n=0 from the next cycle until leaving DONE.
- Read (A always reads; B reads when b_we=0):
  - RD lasts RD_WAIT+1 cycles with sram_oe_n=0.
  - sram_data is sampled into the owner's rdata register at the edge ending the last RD cycle.
- Write (B with b_we=1):
  - WR_SETUP, 1 cycle: data driven, we_n=1.
  - WR_PULSE, WR_PULSE cycles: we_n=0.
  - WR_HOLD, 1 cycle: we_n=1, data still driven.
- sram_data is driven only in WR_SETUP, WR_PULSE and WR_HOLD; it is high-Z in every other state. oe_n and we_n are never both 0.
- DONE, 1 cycle: the owner's ack=1, then the next state is IDLE.
- Latency, counting the grant-sampling cycle as cycle 0:
  - Read ack in cycle RD_WAIT+2 (3 with defaults).
  - Write ack in cycle WR_PULSE+3 (4 with defaults).
- The requester must drop req in the cycle after ack. If req is still high in IDLE, it is a new request.
- Both sides requesting in IDLE: B is granted. A stays pending, waits, and is granted in the IDLE cycle after B's DONE.
- A request arriving during a busy cycle waits; it is never dropped.
- The rdata registers hold their value until the next read for the same side completes.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: a last-owner flag updates at each grant. When both sides request in IDLE, grant the side not granted last. A single pending request is granted regardless of the flag. The flag resets to "A last", so the first contended grant goes to B.
- Undefined: fixed B-over-A priority and no flag register.

Test Plan:
- Reset with a_req=b_req=1 held: all strobes stay 1, sram_data is Z, no acks. Release reset: the first grant is B.
- A read of 0x0040, SRAM model returns 0x1234, defaults: oe_n low for 2 cycles, a_ack in cycle 3, a_rdata=0x1234, stall low from cycle 4.
- B write of 0xBEEF to 0x8001: we_n low exactly 1 cycle, data driven from setup through hold, b_ack in cycle 4, and the model holds 0xBEEF at 0x8001.
- a_req and b_req asserted in the same cycle, fixed priority: B completes first, then A is granted the cycle after B's DONE. With ARB_ROUND_ROBIN_EN, after a B-then-A sequence a fresh contention grants B.
- rst pulled low during WR_PULSE: we_n returns to 1 and the bus goes Z immediately, no b_ack is issued, and the memory word is not required to update.
- RD_WAIT=3, WR_PULSE=2: read ack in cycle 5 and write ack in cycle 5; oe_n and we_n are never low together, checked by assertion.
